// File: rtl/iobus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iobus_arbiter
// Description : Round-robin arbiter sharing one IO bus slave port between
//               NUM_MASTERS strobe-style IO bus masters. Each master's
//               single-cycle request is latched into a private slot, replayed
//               downstream when granted, and the completion (or a timeout
//               abort) is routed back to the owning master.
// Revision    : 1.0 - initial release
// ============================================================================
module iobus_arbiter #(
    parameter int          NUM_MASTERS    = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hffff_ffff,
    localparam int         GW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                      io_clk,
    input  logic                      io_rst,
    // upstream masters
    input  logic [NUM_MASTERS-1:0]    m_io_addr_strobe,
    input  logic [NUM_MASTERS-1:0]    m_io_read_strobe,
    input  logic [NUM_MASTERS-1:0]    m_io_write_strobe,
    input  logic [32*NUM_MASTERS-1:0] m_io_address,
    input  logic [4*NUM_MASTERS-1:0]  m_io_byte_enable,
    input  logic [32*NUM_MASTERS-1:0] m_io_write_data,
    output logic [32*NUM_MASTERS-1:0] m_io_read_data,
    output logic [NUM_MASTERS-1:0]    m_io_ready,
    // downstream slave
    output logic                      s_io_addr_strobe,
    output logic                      s_io_read_strobe,
    output logic                      s_io_write_strobe,
    output logic [31:0]               s_io_address,
    output logic [3:0]                s_io_byte_enable,
    output logic [31:0]               s_io_write_data,
    input  logic [31:0]               s_io_read_data,
    input  logic                      s_io_ready,
    // status
    output logic [GW-1:0]             grant_id,
    output logic                      busy,
    output logic                      timeout_err,
    output logic                      overrun_err
);

    // Counter only needs to reach TIMEOUT_CYCLES-1 before the abort fires.
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] C_CNT_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] C_LAST_MASTER = GW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Request slots
    // ------------------------------------------------------------------
    logic [NUM_MASTERS-1:0] r_pend;
    logic [NUM_MASTERS-1:0] r_rnw;
    logic [31:0]            r_addr  [NUM_MASTERS];
    logic [3:0]             r_be    [NUM_MASTERS];
    logic [31:0]            r_wdata [NUM_MASTERS];

    // ------------------------------------------------------------------
    // Arbiter / downstream state
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [GW-1:0]          r_rr;
    logic [GW-1:0]          r_grant;
    logic [CW-1:0]          r_cnt;
    logic                   r_busy;
    logic                   r_s_addr_strobe;
    logic                   r_s_read_strobe;
    logic                   r_s_write_strobe;
    logic [31:0]            r_s_address;
    logic [3:0]             r_s_be;
    logic [31:0]            r_s_wdata;
    logic [NUM_MASTERS-1:0] r_m_ready;
    logic [31:0]            r_m_rdata [NUM_MASTERS];
    logic                   r_timeout_err;
    logic                   r_overrun_err;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [31:0]            w_m_addr  [NUM_MASTERS];
    logic [3:0]             w_m_be    [NUM_MASTERS];
    logic [31:0]            w_m_wdata [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] w_valid_req;
    logic [NUM_MASTERS-1:0] w_capture;
    logic [NUM_MASTERS-1:0] w_clear;
    logic                   w_overrun;
    logic                   w_done;
    logic                   w_any;
    logic [GW-1:0]          w_pick;
    int                     w_idx;

    // A transaction finishes on slave ready or when the wait budget runs out;
    // ready wins if both coincide so real data is never replaced.
    assign w_done    = (r_state == ST_WAIT) && (s_io_ready || (r_cnt == C_CNT_LAST));
    assign w_overrun = |(w_valid_req & r_pend);

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
            assign w_m_addr[i]  = m_io_address[32*i +: 32];
            assign w_m_be[i]    = m_io_byte_enable[4*i +: 4];
            assign w_m_wdata[i] = m_io_write_data[32*i +: 32];
            // Exactly one qualifier makes a request; none or both is junk.
            assign w_valid_req[i] = m_io_addr_strobe[i] &
                                    (m_io_read_strobe[i] ^ m_io_write_strobe[i]);
            assign w_capture[i]   = w_valid_req[i] & ~r_pend[i];
            assign w_clear[i]     = w_done && (r_grant == GW'(i));
            assign m_io_read_data[32*i +: 32] = r_m_rdata[i];
        end
    endgenerate

    // Round-robin pick: first pending slot at or after the RR pointer.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NUM_MASTERS) begin
                w_idx = w_idx - NUM_MASTERS;
            end
            if (!w_any && r_pend[w_idx]) begin
                w_any  = 1'b1;
                w_pick = GW'(w_idx);
            end
        end
    end

    // Slot capture and release; a slot being served is still full, so a
    // strobe on that edge is an overrun rather than a capture.
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            r_pend <= '0;
            r_rnw  <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                r_addr[i]  <= '0;
                r_be[i]    <= '0;
                r_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (w_clear[i]) begin
                    r_pend[i] <= 1'b0;
                end else if (w_capture[i]) begin
                    r_pend[i]  <= 1'b1;
                    r_rnw[i]   <= m_io_read_strobe[i];
                    r_addr[i]  <= w_m_addr[i];
                    r_be[i]    <= w_m_be[i];
                    r_wdata[i] <= w_m_wdata[i];
                end
            end
        end
    end

    // Grant FSM: issue one downstream pulse, wait for ready or timeout,
    // then hand the result back to the granted master.
    always_ff @(posedge io_clk or posedge io_rst) begin
        if (io_rst) begin
            r_state          <= ST_IDLE;
            r_rr             <= '0;
            r_grant          <= '0;
            r_cnt            <= '0;
            r_busy           <= 1'b0;
            r_s_addr_strobe  <= 1'b0;
            r_s_read_strobe  <= 1'b0;
            r_s_write_strobe <= 1'b0;
            r_s_address      <= '0;
            r_s_be           <= '0;
            r_s_wdata        <= '0;
            r_m_ready        <= '0;
            r_timeout_err    <= 1'b0;
            r_overrun_err    <= 1'b0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                r_m_rdata[i] <= '0;
            end
        end else begin
            // Pulse outputs default low every cycle.
            r_s_addr_strobe  <= 1'b0;
            r_s_read_strobe  <= 1'b0;
            r_s_write_strobe <= 1'b0;
            r_m_ready        <= '0;
            r_timeout_err    <= 1'b0;
            r_overrun_err    <= w_overrun;

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant          <= w_pick;
                        r_s_address      <= r_addr[w_pick];
                        r_s_be           <= r_be[w_pick];
                        r_s_wdata        <= r_wdata[w_pick];
                        r_s_addr_strobe  <= 1'b1;
                        r_s_read_strobe  <= r_rnw[w_pick];
                        r_s_write_strobe <= ~r_rnw[w_pick];
                        r_cnt            <= '0;
                        r_busy           <= 1'b1;
                        r_state          <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // Slave ready during the strobe cycle is not a completion.
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (w_done) begin
                        r_m_ready[r_grant] <= 1'b1;
                        r_m_rdata[r_grant] <= s_io_ready ? s_io_read_data : TIMEOUT_DATA;
                        r_timeout_err      <= ~s_io_ready;
                        r_rr               <= (r_grant == C_LAST_MASTER) ? '0
                                                                         : r_grant + GW'(1);
                        r_busy             <= 1'b0;
                        r_state            <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_io_addr_strobe  = r_s_addr_strobe;
    assign s_io_read_strobe  = r_s_read_strobe;
    assign s_io_write_strobe = r_s_write_strobe;
    assign s_io_address      = r_s_address;
    assign s_io_byte_enable  = r_s_be;
    assign s_io_write_data   = r_s_wdata;
    assign m_io_ready        = r_m_ready;
    assign grant_id          = r_grant;
    assign busy              = r_busy;
    assign timeout_err       = r_timeout_err;
    assign overrun_err       = r_overrun_err;

endmodule
`default_nettype wire
